// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Control-side companion to the system PLL, clocked from the free-running
// reference clock so it keeps working while the PLL output is stopped.
//  - Pulses the PLL reset, then waits a bounded time for lock.
//  - Re-pulses the PLL reset on timeout, up to MAX_RETRIES extra times, and
//    then parks in a FAIL state until a retry request arrives.
//  - Releases the downstream system reset only after lock has been stable
//    for STABLE_CYCLES consecutive cycles.
//  - Restarts the PLL on loss of lock in RUN and counts such events.
//
// Optional feature macro: PLL_SEQ_STATS_EN
//  - defined   : lol_count is a saturating loss-of-lock counter, cleared by
//                clear_stats (a same-cycle loss wins, giving 1).
//  - undefined : lol_count is tied to 0 and clear_stats is ignored.
//
// Ports
//  clk          in   reference clock (same net as PLL refclk)
//  reset_n      in   synchronous active-low reset
//  locked_in    in   PLL lock indication, asynchronous to clk
//  retry_req    in   single-cycle pulse, restarts the sequence from FAIL
//  clear_stats  in   single-cycle pulse, clears lol_count
//  pll_rst      out  active-high PLL reset (high only in RESET_PLL)
//  sys_reset_n  out  active-low system reset (released only in RUN)
//  lock_ok      out  high in RUN
//  fail         out  high in FAIL
//  retry_count  out  retries used in the current sequence
//  lol_count    out  saturating count of loss-of-lock events
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked_in,
  input  logic       retry_req,
  input  logic       clear_stats,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       lock_ok,
  output logic       fail,
  output logic [1:0] retry_count,
  output logic [7:0] lol_count
);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Terminal values of the shared down-time counter for each timed state.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [1:0]       retry_s;
  logic             lol_inc_s;
  logic             sync_meta_r;
  logic             locked_sync_r;

  // Two-flop synchronizer bringing the asynchronous lock flag into clk.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta_r   <= 1'b0;
      locked_sync_r <= 1'b0;
    end else begin
      sync_meta_r   <= locked_in;
      locked_sync_r <= sync_meta_r;
    end
  end

  // FSM state, shared counter and retry counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_RESET_PLL;
      cnt_r       <= CNT_ZERO;
      retry_count <= 2'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      retry_count <= retry_s;
    end
  end

  // Next-state, counter and retry decisions.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    retry_s   = retry_count;
    lol_inc_s = 1'b0;
    case (state_r)
      ST_RESET_PLL: begin
        if (cnt_r == RST_LAST) begin
          state_s = ST_WAIT_LOCK;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_sync_r) begin
          state_s = ST_STABILIZE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == TIMEOUT_LAST) begin
          cnt_s = CNT_ZERO;
          if (retry_count == RETRY_LIMIT) begin
            state_s = ST_FAIL;
          end else begin
            retry_s = retry_count + 2'd1;
            state_s = ST_RESET_PLL;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_STABILIZE: begin
        // A dropout only restarts the lock wait; it does not consume a retry.
        if (!locked_sync_r) begin
          state_s = ST_WAIT_LOCK;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == STABLE_LAST) begin
          state_s = ST_RUN;
          cnt_s   = CNT_ZERO;
          retry_s = 2'd0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!locked_sync_r) begin
          lol_inc_s = 1'b1;
          state_s   = ST_RESET_PLL;
          cnt_s     = CNT_ZERO;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FAIL: begin
        if (retry_req) begin
          retry_s = 2'd0;
          state_s = ST_RESET_PLL;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_FAIL;
        end
      end
      default: begin
        state_s = ST_RESET_PLL;
        cnt_s   = CNT_ZERO;
        retry_s = 2'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      lock_ok     <= 1'b0;
      fail        <= 1'b0;
    end else begin
      pll_rst     <= (state_s == ST_RESET_PLL);
      sys_reset_n <= (state_s == ST_RUN);
      lock_ok     <= (state_s == ST_RUN);
      fail        <= (state_s == ST_FAIL);
    end
  end

`ifdef PLL_SEQ_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'd255) begin
      sat_inc8 = 8'd255;
    end else begin
      sat_inc8 = value + 8'd1;
    end
  endfunction

  // Loss-of-lock counter; an increment in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lol_count <= 8'd0;
    end else if (lol_inc_s) begin
      lol_count <= clear_stats ? 8'd1 : sat_inc8(lol_count);
    end else if (clear_stats) begin
      lol_count <= 8'd0;
    end else begin
      lol_count <= lol_count;
    end
  end
`else
  logic unused_stats_s;
  assign unused_stats_s = clear_stats ^ lol_inc_s;
  assign lol_count      = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for pll_reset_sequencer with
// RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

`ifdef PLL_SEQ_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       locked_in;
  logic       retry_req;
  logic       clear_stats;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       lock_ok;
  logic       fail;
  logic [1:0] retry_count;
  logic [7:0] lol_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .STABLE_CYCLES      (8),
    .MAX_RETRIES        (2),
    .CNT_W              (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .locked_in  (locked_in),
    .retry_req  (retry_req),
    .clear_stats(clear_stats),
    .pll_rst    (pll_rst),
    .sys_reset_n(sys_reset_n),
    .lock_ok    (lock_ok),
    .fail       (fail),
    .retry_count(retry_count),
    .lol_count  (lol_count)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the number of edges until sys_reset_n equals level, or -1.
  task automatic wait_sys(input logic level, input int limit, output int n);
    bit done;
    done = 1'b0;
    n    = -1;
    for (int i = 1; i <= limit; i++) begin
      if (!done) begin
        step(1);
        if (sys_reset_n === level) begin
          n    = i;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    locked_in   = 1'b0;
    retry_req   = 1'b0;
    clear_stats = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
    checks++; if (sys_reset_n !== 1'b0) begin failures++; $display("FAIL reset_sys_reset_n: got %b expected 0", sys_reset_n); end
    checks++; if (lock_ok !== 1'b0 || fail !== 1'b0) begin failures++; $display("FAIL reset_flags: got lock_ok=%b fail=%b expected 0/0", lock_ok, fail); end
    checks++; if (retry_count !== 2'd0 || lol_count !== 8'd0) begin failures++; $display("FAIL reset_counts: got retry=%0d lol=%0d expected 0/0", retry_count, lol_count); end
  endtask

  task automatic test_clean_lock();
    do_reset();
    reset_n = 1'b1;
    step(3);
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL clean_pulse_edge3: got %b expected 1", pll_rst); end
    step(1);
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL clean_pulse_edge4: got %b expected 0", pll_rst); end
    step(6);
    locked_in = 1'b1;
    step(10);  // first sample high is the 1st of these edges (E0), now at E0+9
    checks++; if (sys_reset_n !== 1'b0) begin failures++; $display("FAIL clean_release_early: got %b expected 0", sys_reset_n); end
    step(1);
    checks++; if (sys_reset_n !== 1'b1 || lock_ok !== 1'b1) begin failures++; $display("FAIL clean_release: got sys=%b lock_ok=%b expected 1/1", sys_reset_n, lock_ok); end
    checks++; if (retry_count !== 2'd0 || pll_rst !== 1'b0 || fail !== 1'b0) begin failures++; $display("FAIL clean_run_state: got retry=%0d pll_rst=%b fail=%b expected 0/0/0", retry_count, pll_rst, fail); end
    retry_req = 1'b1;
    step(1);
    retry_req = 1'b0;
    step(1);
    checks++; if (sys_reset_n !== 1'b1 || pll_rst !== 1'b0 || fail !== 1'b0) begin failures++; $display("FAIL retry_req_in_run: got sys=%b pll_rst=%b fail=%b expected 1/0/0", sys_reset_n, pll_rst, fail); end
  endtask

  task automatic test_timeout_retry();
    do_reset();
    reset_n = 1'b1;
    step(4);
    checks++; if (pll_rst !== 1'b0 || retry_count !== 2'd0) begin failures++; $display("FAIL retry_first_pulse_end: got pll_rst=%b retry=%0d expected 0/0", pll_rst, retry_count); end
    step(19);
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL retry_gap_end: got %b expected 0", pll_rst); end
    step(1);
    checks++; if (pll_rst !== 1'b1 || retry_count !== 2'd1) begin failures++; $display("FAIL retry_second_pulse: got pll_rst=%b retry=%0d expected 1/1", pll_rst, retry_count); end
    step(3);
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL retry_second_pulse_len: got %b expected 1", pll_rst); end
    step(1);
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL retry_second_pulse_end: got %b expected 0", pll_rst); end
    locked_in = 1'b1;
    step(10);
    checks++; if (sys_reset_n !== 1'b0 || retry_count !== 2'd1) begin failures++; $display("FAIL retry_before_run: got sys=%b retry=%0d expected 0/1", sys_reset_n, retry_count); end
    step(1);
    checks++; if (sys_reset_n !== 1'b1 || retry_count !== 2'd0) begin failures++; $display("FAIL retry_after_run: got sys=%b retry=%0d expected 1/0", sys_reset_n, retry_count); end
  endtask

  task automatic test_permanent_fail();
    int   falls;
    int   rises;
    logic prev;
    do_reset();
    reset_n = 1'b1;
    falls   = 0;
    rises   = 0;
    prev    = pll_rst;
    for (int i = 1; i <= 71; i++) begin
      step(1);
      if (prev === 1'b1 && pll_rst === 1'b0) falls++;
      if (prev === 1'b0 && pll_rst === 1'b1) rises++;
      prev = pll_rst;
    end
    checks++; if (falls != 3 || rises != 2) begin failures++; $display("FAIL fail_pulse_count: got falls=%0d rises=%0d expected 3/2", falls, rises); end
    checks++; if (fail !== 1'b0) begin failures++; $display("FAIL fail_too_early: got %b expected 0", fail); end
    step(1);
    checks++; if (fail !== 1'b1 || sys_reset_n !== 1'b0 || pll_rst !== 1'b0) begin failures++; $display("FAIL fail_entry: got fail=%b sys=%b pll_rst=%b expected 1/0/0", fail, sys_reset_n, pll_rst); end
    checks++; if (retry_count !== 2'd2 || lock_ok !== 1'b0) begin failures++; $display("FAIL fail_retry_count: got retry=%0d lock_ok=%b expected 2/0", retry_count, lock_ok); end
    step(5);
    checks++; if (fail !== 1'b1 || pll_rst !== 1'b0) begin failures++; $display("FAIL fail_hold: got fail=%b pll_rst=%b expected 1/0", fail, pll_rst); end
    retry_req = 1'b1;
    step(1);
    retry_req = 1'b0;
    checks++; if (pll_rst !== 1'b1 || fail !== 1'b0 || retry_count !== 2'd0) begin failures++; $display("FAIL fail_retry_req: got pll_rst=%b fail=%b retry=%0d expected 1/0/0", pll_rst, fail, retry_count); end
    step(3);
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL fail_restart_len: got %b expected 1", pll_rst); end
    step(1);
    checks++; if (pll_rst !== 1'b0 || fail !== 1'b0) begin failures++; $display("FAIL fail_restart_end: got pll_rst=%b fail=%b expected 0/0", pll_rst, fail); end
  endtask

  task automatic test_unstable_lock();
    do_reset();
    reset_n = 1'b1;
    step(10);
    locked_in = 1'b1;
    step(5);
    locked_in = 1'b0;
    step(1);
    locked_in = 1'b1;
    step(10);  // high again from the 1st of these edges; now 9 edges later
    checks++; if (sys_reset_n !== 1'b0 || retry_count !== 2'd0) begin failures++; $display("FAIL unstable_no_early_release: got sys=%b retry=%0d expected 0/0", sys_reset_n, retry_count); end
    step(1);
    checks++; if (sys_reset_n !== 1'b1 || lock_ok !== 1'b1 || retry_count !== 2'd0) begin failures++; $display("FAIL unstable_release: got sys=%b lock_ok=%b retry=%0d expected 1/1/0", sys_reset_n, lock_ok, retry_count); end
  endtask

  task automatic test_loss_of_lock();
    int         n;
    int         bad;
    logic [7:0] exp_lol;
    do_reset();
    locked_in = 1'b1;
    reset_n   = 1'b1;
    wait_sys(1'b1, 60, n);
    checks++; if (n != 13) begin failures++; $display("FAIL loss_initial_run: got %0d edges expected 13", n); end
    locked_in = 1'b0;
    step(2);
    checks++; if (sys_reset_n !== 1'b1) begin failures++; $display("FAIL loss_too_early: got %b expected 1", sys_reset_n); end
    step(1);
    exp_lol = STATS_EN ? 8'd1 : 8'd0;
    checks++; if (sys_reset_n !== 1'b0 || lock_ok !== 1'b0 || pll_rst !== 1'b1) begin failures++; $display("FAIL loss_outputs: got sys=%b lock_ok=%b pll_rst=%b expected 0/0/1", sys_reset_n, lock_ok, pll_rst); end
    checks++; if (lol_count !== exp_lol) begin failures++; $display("FAIL loss_lol_first: got %0d expected %0d", lol_count, exp_lol); end
    locked_in = 1'b1;
    wait_sys(1'b1, 60, n);
    checks++; if (n != 13) begin failures++; $display("FAIL loss_recover: got %0d edges expected 13", n); end
    bad = 0;
    for (int i = 2; i <= 256; i++) begin
      locked_in = 1'b0;
      wait_sys(1'b0, 10, n);
      if (n < 0) bad++;
      locked_in = 1'b1;
      wait_sys(1'b1, 60, n);
      if (n < 0) bad++;
      if (i == 255) begin
        exp_lol = STATS_EN ? 8'd255 : 8'd0;
        checks++; if (lol_count !== exp_lol) begin failures++; $display("FAIL loss_lol_255: got %0d expected %0d", lol_count, exp_lol); end
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL loss_loop_timeout: got %0d expired waits expected 0", bad); end
    exp_lol = STATS_EN ? 8'd255 : 8'd0;
    checks++; if (lol_count !== exp_lol) begin failures++; $display("FAIL loss_lol_saturate: got %0d expected %0d", lol_count, exp_lol); end
    locked_in = 1'b0;
    step(2);
    clear_stats = 1'b1;
    step(1);
    clear_stats = 1'b0;
    exp_lol = STATS_EN ? 8'd1 : 8'd0;
    checks++; if (lol_count !== exp_lol || sys_reset_n !== 1'b0) begin failures++; $display("FAIL loss_clear_same_cycle: got lol=%0d sys=%b expected %0d/0", lol_count, sys_reset_n, exp_lol); end
    locked_in = 1'b1;
    wait_sys(1'b1, 60, n);
    clear_stats = 1'b1;
    step(1);
    clear_stats = 1'b0;
    checks++; if (lol_count !== 8'd0 || sys_reset_n !== 1'b1) begin failures++; $display("FAIL loss_clear: got lol=%0d sys=%b expected 0/1", lol_count, sys_reset_n); end
  endtask

  task automatic test_midop_reset();
    int         n;
    int         bad;
    logic [7:0] exp_lol;
    do_reset();
    locked_in = 1'b1;
    reset_n   = 1'b1;
    wait_sys(1'b1, 60, n);
    bad = (n < 0) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      locked_in = 1'b0;
      wait_sys(1'b0, 10, n);
      if (n < 0) bad++;
      locked_in = 1'b1;
      if (i < 2) begin
        wait_sys(1'b1, 60, n);
        if (n < 0) bad++;
      end
    end
    step(7);  // RESET_PLL -> WAIT_LOCK -> STABILIZE, two edges into STABILIZE
    checks++; if (bad != 0 || pll_rst !== 1'b0 || sys_reset_n !== 1'b0) begin failures++; $display("FAIL midop_in_stabilize: got bad=%0d pll_rst=%b sys=%b expected 0/0/0", bad, pll_rst, sys_reset_n); end
    exp_lol = STATS_EN ? 8'd3 : 8'd0;
    checks++; if (lol_count !== exp_lol) begin failures++; $display("FAIL midop_lol_before: got %0d expected %0d", lol_count, exp_lol); end
    reset_n = 1'b0;
    step(1);
    checks++; if (pll_rst !== 1'b1 || sys_reset_n !== 1'b0 || lock_ok !== 1'b0 || fail !== 1'b0) begin failures++; $display("FAIL midop_reset_outputs: got pll_rst=%b sys=%b lock_ok=%b fail=%b expected 1/0/0/0", pll_rst, sys_reset_n, lock_ok, fail); end
    checks++; if (retry_count !== 2'd0 || lol_count !== 8'd0) begin failures++; $display("FAIL midop_reset_counts: got retry=%0d lol=%0d expected 0/0", retry_count, lol_count); end
  endtask

  initial begin
    reset_n     = 1'b0;
    locked_in   = 1'b0;
    retry_req   = 1'b0;
    clear_stats = 1'b0;
    test_reset();
    test_clean_lock();
    test_timeout_retry();
    test_permanent_fail();
    test_unstable_lock();
    test_loss_of_lock();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
